// File: rtl/game_mmo_regs.sv
// Register slave on the HPS mmo conduit: tick timer, score register, button-event FIFO, level IRQ.
// Optional per-bit button debounce is enabled by defining GAME_DEBOUNCE_EN.
module game_mmo_regs #(
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] TICK_DIV_RST = 32'd49999,
  parameter logic [19:0] DB_CYCLES    = 20'd500000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_soft_reset,
  input  logic [4:0]  i_address,
  input  logic [31:0] i_writedata,
  input  logic [3:0]  i_byteenable,
  input  logic        i_read,
  input  logic        i_write,
  output logic [31:0] o_readdata,
  input  logic [4:0]  i_buttons,
  output logic        o_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] ID_VALUE = 32'h47414D45;

  logic [2:0]    ctrl;
  logic [31:0]   tick_div, presc, tick_count, score;
  logic [1:0]    irq_mask;
  logic          ovf;
  logic [4:0]    sync1, sync2, stable, prev;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [8:0]    count9;
  logic [31:0]   rd_mux;
  logic          wr_en, rd_en, empty, full, push, pop, do_push;

  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // write wins over a simultaneous read
  assign wr_en   = i_write;
  assign rd_en   = i_read & ~i_write;
  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign count9  = 9'(count);
  assign push    = ctrl[1] & (stable != prev);
  assign pop     = rd_en & (i_address == 5'd3) & ~empty;
  assign do_push = push & (~full | pop);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else if (i_soft_reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= i_buttons;
      sync2 <= sync1;
      prev  <= stable;
    end
  end

`ifdef GAME_DEBOUNCE_EN
  logic [19:0] db_cnt [5];

  // down-counter per bit; stable bit follows only after DB_CYCLES consecutive differing clocks
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stable <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= DB_CYCLES - 20'd1;
    end else if (i_soft_reset) begin
      stable <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= DB_CYCLES - 20'd1;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= DB_CYCLES - 20'd1;
        end else if (db_cnt[i] == 20'd0) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= DB_CYCLES - 20'd1;
        end else begin
          db_cnt[i] <= db_cnt[i] - 20'd1;
        end
      end
    end
  end
`else
  logic unused_db;
  assign unused_db = ^DB_CYCLES;
  always_comb stable = sync2;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc      <= '0;
      tick_count <= '0;
    end else if (i_soft_reset) begin
      presc      <= '0;
      tick_count <= '0;
    end else if (wr_en && i_address == 5'd4) begin
      presc <= '0;
    end else if (ctrl[0]) begin
      if (presc == tick_div) begin
        presc      <= '0;
        tick_count <= tick_count + 32'd1;
      end else begin
        presc <= presc + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= {tick_count[23:0], 3'b000, stable};
  end

  always_comb begin
    rd_mux = '0;
    case (i_address)
      5'd0:    rd_mux = ID_VALUE;
      5'd1:    rd_mux = {29'd0, ctrl};
      5'd2:    rd_mux = {20'd0, ovf, full, empty, count9};
      5'd3:    rd_mux = empty ? 32'd0 : mem[rd_ptr];
      5'd4:    rd_mux = tick_div;
      5'd5:    rd_mux = tick_count;
      5'd6:    rd_mux = score;
      5'd7:    rd_mux = {30'd0, irq_mask};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ctrl       <= '0;
      tick_div   <= TICK_DIV_RST;
      score      <= '0;
      irq_mask   <= '0;
      ovf        <= 1'b0;
      o_readdata <= '0;
      o_irq      <= 1'b0;
    end else if (i_soft_reset) begin
      ctrl       <= '0;
      tick_div   <= TICK_DIV_RST;
      score      <= '0;
      irq_mask   <= '0;
      ovf        <= 1'b0;
      o_readdata <= '0;
      o_irq      <= 1'b0;
    end else begin
      // SCORE_CLR is a one-cycle pulse that takes priority over a same-cycle SCORE write
      ctrl[2] <= 1'b0;
      if (ctrl[2]) score <= '0;
      else if (wr_en && i_address == 5'd6) score <= be_merge(score, i_writedata, i_byteenable);
      if (wr_en && i_address == 5'd1 && i_byteenable[0]) ctrl <= i_writedata[2:0];
      if (wr_en && i_address == 5'd4) tick_div <= be_merge(tick_div, i_writedata, i_byteenable);
      if (wr_en && i_address == 5'd7 && i_byteenable[0]) irq_mask <= i_writedata[1:0];
      if (push && full && !pop) ovf <= 1'b1;
      else if (wr_en && i_address == 5'd2 && i_byteenable[1] && i_writedata[11]) ovf <= 1'b0;
      if (rd_en) o_readdata <= rd_mux;
      o_irq <= (irq_mask[0] & ~empty) | (irq_mask[1] & ovf);
    end
  end
endmodule

// File: tb/tb_game_mmo_regs.sv
// Self-checking bench for game_mmo_regs (default build, no debounce); read and event scoreboards.
module tb_game_mmo_regs;
  logic        clk = 1'b0;
  logic        rst_n, soft_reset, read, write, irq;
  logic [4:0]  address, buttons;
  logic [31:0] writedata, readdata;
  logic [3:0]  byteenable;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] ev_q [$];
  logic [31:0] got, want;
  logic [31:0] tick_model;
  localparam logic [31:0] ID = 32'h47414D45;

  game_mmo_regs dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_soft_reset(soft_reset), .i_address(address),
    .i_writedata(writedata), .i_byteenable(byteenable), .i_read(read), .i_write(write),
    .o_readdata(readdata), .i_buttons(buttons), .o_irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic press(input logic [4:0] v);
    buttons = v;
    idle(4);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; soft_reset = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; byteenable = '0; buttons = '0;
    tick_model = 0;
    idle(2);
    n_cmp++; if (readdata !== 32'd0) begin n_err++; $display("FAIL reset_readdata: got %h want 0", readdata); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst_n = 1'b1;
    idle(1);
    exp_q.push_back(ID); rd(0, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL reset_id: got %h want %h", got, want); end
    exp_q.push_back(32'd49999); rd(4, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL reset_tickdiv: got %h want %h", got, want); end
    exp_q.push_back(32'h200); rd(2, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL reset_status: got %h want %h", got, want); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq_after: got %b want 0", irq); end
  endtask

  task automatic test_tick;
    wr(4, 32'd3, 4'hf);
    wr(1, 32'd1, 4'hf); idle(3); wr(1, 32'd0, 4'hf);
    tick_model = 1;
    exp_q.push_back(tick_model); rd(5, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL tick_4clk: got %0d want %0d", got, want); end
    wr(1, 32'd1, 4'hf); idle(35); wr(1, 32'd0, 4'hf);
    tick_model = 10;
    exp_q.push_back(tick_model); rd(5, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL tick_40clk: got %0d want %0d", got, want); end
    wr(4, 32'd0, 4'hf);
    wr(1, 32'd1, 4'hf); idle(4); wr(1, 32'd0, 4'hf);
    tick_model = 15;
    exp_q.push_back(tick_model); rd(5, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL tick_div0: got %0d want %0d", got, want); end
    // prescaler restart on TICK_DIV write: 1 + (restart) + 3 steps never reaches the wrap
    wr(4, 32'd3, 4'hf);
    wr(1, 32'd1, 4'hf); idle(1); wr(4, 32'd3, 4'hf); idle(2); wr(1, 32'd0, 4'hf);
    exp_q.push_back(tick_model); rd(5, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL tick_div_restart: got %0d want %0d", got, want); end
    wr(1, 32'd1, 4'hf); wr(1, 32'd0, 4'hf);
    tick_model = 16;
    exp_q.push_back(tick_model); rd(5, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL tick_wrap_step: got %0d want %0d", got, want); end
  endtask

  task automatic test_event;
    wr(1, 32'd2, 4'h1);
    ev_q.push_back({tick_model[23:0], 3'b000, 5'h01}); press(5'h01);
    exp_q.push_back(32'h001); rd(2, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL event_status: got %h want %h", got, want); end
    rd(3, got); want = ev_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL event_data: got %h want %h", got, want); end
    exp_q.push_back(32'h200); rd(2, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL event_empty: got %h want %h", got, want); end
    exp_q.push_back(32'd0); rd(3, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL event_read_empty: got %h want %h", got, want); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 17; i++) begin
      logic [4:0] v;
      v = 5'(i + 2);
      if (i < 16) ev_q.push_back({tick_model[23:0], 3'b000, v});
      press(v);
    end
    exp_q.push_back(32'hC10); rd(2, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL ovf_status: got %h want %h", got, want); end
    wr(7, 32'd2, 4'h1); idle(1);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL ovf_irq: got %b want 1", irq); end
    wr(2, 32'h800, 4'b0010); idle(1);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL ovf_irq_clear: got %b want 0", irq); end
    wr(7, 32'd0, 4'h1);
    exp_q.push_back(32'h410); rd(2, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL ovf_w1c: got %h want %h", got, want); end
  endtask

  task automatic test_back_to_back;
    // push and pop land on the same edge while full
    ev_q.push_back({tick_model[23:0], 3'b000, 5'h1f});
    buttons = 5'h1f; idle(2);
    rd(3, got); want = ev_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL full_pushpop_data: got %h want %h", got, want); end
    exp_q.push_back(32'h410); rd(2, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL full_pushpop_status: got %h want %h", got, want); end
    for (int i = 0; i < 16; i++) begin
      rd(3, got); want = ev_q.pop_front();
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL drain_%0d: got %h want %h", i, got, want); end
    end
    exp_q.push_back(32'h200); rd(2, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL drain_empty: got %h want %h", got, want); end
  endtask

  task automatic test_irq;
    wr(7, 32'd1, 4'h1); idle(1);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_idle: got %b want 0", irq); end
    ev_q.push_back({tick_model[23:0], 3'b000, 5'h00}); press(5'h00);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b want 1", irq); end
    rd(3, got); want = ev_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL irq_pop_data: got %h want %h", got, want); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_delay: got %b want 1", irq); end
    idle(1);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b want 0", irq); end
    wr(7, 32'd0, 4'h1);
  endtask

  task automatic test_score;
    wr(6, 32'hAABBCCDD, 4'b0010);
    exp_q.push_back(32'h0000CC00); rd(6, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL score_byte: got %h want %h", got, want); end
    wr(6, 32'h11223344, 4'hf);
    exp_q.push_back(32'h11223344); rd(6, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL score_full: got %h want %h", got, want); end
    wr(1, 32'd4, 4'h1); idle(1);
    exp_q.push_back(32'd0); rd(6, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL score_clr: got %h want %h", got, want); end
    exp_q.push_back(32'd0); rd(1, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL ctrl_selfclear: got %h want %h", got, want); end
    rd(0, got);
    address = 5'd6; writedata = 32'h55; byteenable = 4'hf; read = 1'b1; write = 1'b1;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    n_cmp++; if (readdata !== ID) begin n_err++; $display("FAIL rdwr_hold: got %h want %h", readdata, ID); end
    wr(6, 32'h77000000, 4'b1000);
    exp_q.push_back(32'h77000055); rd(6, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL rdwr_write_wins: got %h want %h", got, want); end
    wr(0, 32'h0, 4'hf);
    exp_q.push_back(ID); rd(0, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL ro_write: got %h want %h", got, want); end
    exp_q.push_back(32'd0); rd(9, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL unmapped: got %h want %h", got, want); end
  endtask

  task automatic test_soft_reset;
    wr(4, 32'd7, 4'hf); wr(7, 32'd3, 4'h1); wr(1, 32'd1, 4'h1); idle(20);
    soft_reset = 1'b1; idle(1); soft_reset = 1'b0;
    n_cmp++; if (readdata !== 32'd0) begin n_err++; $display("FAIL soft_readdata: got %h want 0", readdata); end
    exp_q.push_back(32'd49999); rd(4, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL soft_tickdiv: got %h want %h", got, want); end
    exp_q.push_back(32'd0); rd(6, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL soft_score: got %h want %h", got, want); end
    exp_q.push_back(32'd0); rd(5, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL soft_tickcount: got %h want %h", got, want); end
    exp_q.push_back(32'd0); rd(7, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL soft_mask: got %h want %h", got, want); end
    wr(6, 32'h99, 4'hf);
    address = 5'd6; read = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    read = 1'b0; rst_n = 1'b1;
    n_cmp++; if (readdata !== 32'd0) begin n_err++; $display("FAIL midaccess_readdata: got %h want 0", readdata); end
    exp_q.push_back(32'd0); rd(6, got); want = exp_q.pop_front();
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL midaccess_score: got %h want %h", got, want); end
  endtask

  initial begin
    test_reset;
    test_tick;
    test_event;
    test_overflow;
    test_back_to_back;
    test_irq;
    test_score;
    test_soft_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
